// File: rtl/reconfig_tmr_nb.sv
// Programmable down-count timer with a configurable-width output pulse.
// Periodic or one-shot operation; paces LFSR stepping downstream.
module reconfig_tmr_nb #(
   parameter int WIDTH   = 8,
   parameter int PULSE_W = 1
) (
   input  logic             pulseClk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             start,
   input  logic             loadNow,
   input  logic [WIDTH-1:0] timeAdj,
   output logic             pulseROut,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   localparam int PW = $clog2(PULSE_W + 1);
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
   localparam logic [PW-1:0]    P_ONE  = PW'(1);
   localparam logic [PW-1:0]    P_LAST = PW'(PULSE_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COUNT,
      PULSE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             done_q, done_d;

   always_ff @(posedge pulseClk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      done_d  = done_q;
      // done clears on an IDLE start even while disabled
      if (state_q == IDLE && start) begin
         done_d = 1'b0;
      end
      if (!en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!mode || start) begin
                  state_d = LOAD;
               end
            end
            LOAD: begin
               cnt_d   = timeAdj;
               pcnt_d  = '0;
               state_d = COUNT;
            end
            COUNT: begin
               if (loadNow) begin
                  cnt_d = timeAdj;
               end else if (cnt_q != '0) begin
                  cnt_d = cnt_q - C_ONE;
               end else begin
                  state_d = PULSE;
               end
            end
            PULSE: begin
               // saturates at PULSE_W on exit; LOAD clears it
               pcnt_d = pcnt_q + P_ONE;
               if (pcnt_q == P_LAST) begin
                  if (mode) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end
         endcase
      end
   end

   assign pulseROut = (state_q == PULSE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign count     = cnt_q;

endmodule

// File: tb/tb_reconfig_tmr_nb.sv
// Bench for reconfig_tmr_nb: three instances (PULSE_W 1/3/4) on shared
// inputs, directed scenarios plus random traffic against a phase model.
module tb_reconfig_tmr_nb;

   logic       clk = 1'b0;
   logic       rst, en, mode, start, ld;
   logic [7:0] adj;

   logic [2:0]      pls, bsy, dn;
   logic [2:0][7:0] cnt;

   int total = 0;
   int bad   = 0;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_COUNT = 2;
   localparam int M_PULSE = 3;

   typedef struct packed {
      int ph;
      int c;
      int left;
      bit dn;
   } mdl_t;

   mdl_t m [3];

   always #5 clk = ~clk;

   reconfig_tmr_nb #(.WIDTH(8), .PULSE_W(1)) u1 (
      .pulseClk(clk), .rst(rst), .en(en), .mode(mode),
      .start(start), .loadNow(ld), .timeAdj(adj),
      .pulseROut(pls[0]), .busy(bsy[0]), .done(dn[0]),
      .count(cnt[0]));

   reconfig_tmr_nb #(.WIDTH(8), .PULSE_W(3)) u3 (
      .pulseClk(clk), .rst(rst), .en(en), .mode(mode),
      .start(start), .loadNow(ld), .timeAdj(adj),
      .pulseROut(pls[1]), .busy(bsy[1]), .done(dn[1]),
      .count(cnt[1]));

   reconfig_tmr_nb #(.WIDTH(8), .PULSE_W(4)) u4 (
      .pulseClk(clk), .rst(rst), .en(en), .mode(mode),
      .start(start), .loadNow(ld), .timeAdj(adj),
      .pulseROut(pls[2]), .busy(bsy[2]), .done(dn[2]),
      .count(cnt[2]));

   function automatic int pwof(int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 4;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int pw);
      mdl_t n = s;
      if (!rst) begin
         n.ph = M_IDLE; n.c = 0; n.left = 0; n.dn = 1'b0;
         return n;
      end
      if (s.ph == M_IDLE && start) n.dn = 1'b0;
      if (!en) begin
         n.ph = M_IDLE;
         return n;
      end
      case (s.ph)
         M_IDLE: if (!mode || start) n.ph = M_LOAD;
         M_LOAD: begin
            n.c = int'(adj); n.left = pw; n.ph = M_COUNT;
         end
         M_COUNT: begin
            if (ld) n.c = int'(adj);
            else if (s.c > 0) n.c = s.c - 1;
            else n.ph = M_PULSE;
         end
         default: begin
            n.left = s.left - 1;
            if (n.left == 0) begin
               if (mode) begin
                  n.ph = M_IDLE; n.dn = 1'b1;
               end else begin
                  n.ph = M_LOAD;
               end
            end
         end
      endcase
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 3; k++) m[k] = mstep(m[k], pwof(k));
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic meas(input int k, input int n,
                       output int r1, output int r2, output int hi);
      logic prev;
      r1 = -1; r2 = -1; hi = 0;
      prev = pls[k];
      for (int t = 1; t <= n; t++) begin
         step();
         if (pls[k] && !prev) begin
            if (r1 < 0) r1 = t;
            else if (r2 < 0) r2 = t;
         end
         if (pls[k] && r1 >= 0 && r2 < 0) hi++;
         prev = pls[k];
      end
   endtask

   task automatic test_reset();
      int rise;
      rst = 1'b0; en = 1'b1; mode = 1'b0; start = 1'b0;
      ld = 1'b0; adj = 8'd5;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({pls, bsy, dn, cnt} !== '0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got pls=%b bsy=%b dn=%b cnt=%h want all 0",
                     i, pls, bsy, dn, cnt);
         end
      end
      rst = 1'b1;
      rise = -1;
      for (int t = 1; t <= 20; t++) begin
         step();
         if (pls[0] && rise < 0) rise = t;
      end
      total++;
      if (rise != 8) begin
         bad++;
         $display("FAIL first_pulse got cycle %0d want 8", rise);
      end
   endtask

   task automatic test_periodic();
      int r1, r2, hi, w;
      meas(0, 40, r1, r2, hi);
      total++;
      if (r2 - r1 != 8 || hi != 1) begin
         bad++;
         $display("FAIL periodic_pw1 got period=%0d high=%0d want 8/1", r2 - r1, hi);
      end
      meas(1, 40, r1, r2, hi);
      total++;
      if (r2 - r1 != 10 || hi != 3) begin
         bad++;
         $display("FAIL periodic_pw3 got period=%0d high=%0d want 10/3", r2 - r1, hi);
      end
      w = 0;
      while (!pls[0] && w < 20) begin
         step(); w++;
      end
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if (cnt[0] !== 8'(5 - i)) begin
            bad++;
            $display("FAIL count_seq idx=%0d got %0d want %0d", i, cnt[0], 5 - i);
         end
      end
   endtask

   task automatic test_wide_full();
      int r1, r2, hi;
      adj = 8'd0;
      rst_pulse();
      meas(1, 30, r1, r2, hi);
      total++;
      if (r2 - r1 != 5 || hi != 3) begin
         bad++;
         $display("FAIL wide_pw3 got period=%0d high=%0d want 5/3", r2 - r1, hi);
      end
      meas(2, 30, r1, r2, hi);
      total++;
      if (r2 - r1 != 6 || hi != 4) begin
         bad++;
         $display("FAIL wide_pw4 got period=%0d high=%0d want 6/4", r2 - r1, hi);
      end
      adj = 8'd255;
      rst_pulse();
      meas(0, 600, r1, r2, hi);
      total++;
      if (r2 - r1 != 258 || hi != 1) begin
         bad++;
         $display("FAIL full_scale got period=%0d high=%0d want 258/1", r2 - r1, hi);
      end
   endtask

   task automatic test_oneshot();
      int rise, nr;
      logic prev;
      mode = 1'b1; adj = 8'd4;
      rst_pulse();
      step();
      rise = -1; nr = 0; prev = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         start = (t == 1 || t == 4);
         step();
         if (pls[0] && !prev) begin
            nr++;
            if (rise < 0) rise = t;
         end
         prev = pls[0];
      end
      start = 1'b0;
      total++;
      if (rise != 7 || nr != 1) begin
         bad++;
         $display("FAIL oneshot_pulse got rise=%0d count=%0d want 7/1", rise, nr);
      end
      total++;
      if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
         bad++;
         $display("FAIL oneshot_done got done=%b busy=%b want 1/0", dn[0], bsy[0]);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b1) begin
         bad++;
         $display("FAIL retrigger got done=%b busy=%b want 0/1", dn[0], bsy[0]);
      end
      rise = -1;
      for (int t = 2; t <= 20; t++) begin
         step();
         if (pls[0] && rise < 0) rise = t;
      end
      total++;
      if (rise != 7) begin
         bad++;
         $display("FAIL retrigger_pulse got rise=%0d want 7", rise);
      end
   endtask

   task automatic test_loadnow();
      int w, rise;
      mode = 1'b0; adj = 8'd10;
      rst_pulse();
      w = 0;
      while (cnt[0] != 8'd3 && w < 40) begin
         step(); w++;
      end
      total++;
      if (w >= 40) begin
         bad++;
         $display("FAIL loadnow_wait got timeout want count 3");
      end
      adj = 8'd6; ld = 1'b1;
      step();
      ld = 1'b0;
      total++;
      if (cnt[0] !== 8'd6) begin
         bad++;
         $display("FAIL loadnow_reload got %0d want 6", cnt[0]);
      end
      rise = -1;
      for (int t = 1; t <= 12; t++) begin
         step();
         if (pls[0] && rise < 0) rise = t;
      end
      total++;
      if (rise != 7) begin
         bad++;
         $display("FAIL loadnow_delay got rise=%0d want 7", rise);
      end
      w = 0;
      while (!(cnt[0] == 8'd1 && bsy[0] && !pls[0]) && w < 40) begin
         step(); w++;
      end
      step();
      ld = 1'b1;
      step();
      ld = 1'b0;
      total++;
      if (cnt[0] !== 8'd6 || pls[0] !== 1'b0 || w >= 40) begin
         bad++;
         $display("FAIL loadnow_at_zero got cnt=%0d pls=%b want 6/0", cnt[0], pls[0]);
      end
   endtask

   task automatic test_abort();
      int w;
      mode = 1'b0; adj = 8'd2;
      rst_pulse();
      w = 0;
      while (!pls[2] && w < 30) begin
         step(); w++;
      end
      step();
      en = 1'b0;
      step();
      total++;
      if (pls[2] !== 1'b0 || bsy[2] !== 1'b0 || dn[2] !== 1'b0 ||
          cnt[2] !== 8'd0 || w >= 30) begin
         bad++;
         $display("FAIL abort_en got pls=%b bsy=%b dn=%b cnt=%0d want 0/0/0/0",
                  pls[2], bsy[2], dn[2], cnt[2]);
      end
      en = 1'b1; adj = 8'd10;
      w = 0;
      while (!(cnt[0] == 8'd5 && bsy[0]) && w < 40) begin
         step(); w++;
      end
      rst = 1'b0;
      step();
      total++;
      if ({pls, bsy, dn, cnt} !== '0 || w >= 40) begin
         bad++;
         $display("FAIL abort_rst got pls=%b bsy=%b dn=%b cnt=%h want all 0",
                  pls, bsy, dn, cnt);
      end
      rst = 1'b1;
   endtask

   task automatic test_random();
      logic [10:0] got, exp;
      logic        mbias;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) mbias = $urandom_range(0, 1);
         rst   = ($urandom % 100) != 0;
         en    = ($urandom % 16) != 0;
         mode  = mbias ^ (($urandom % 20) == 0);
         start = ($urandom % 8) == 0;
         ld    = ($urandom % 10) == 0;
         adj   = 8'($urandom_range(0, 9));
         step();
         for (int k = 0; k < 3; k++) begin
            got = {pls[k], bsy[k], dn[k], cnt[k]};
            exp = {m[k].ph == M_PULSE, m[k].ph != M_IDLE, m[k].dn, 8'(m[k].c)};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL random k=%0d cyc=%0d got %h want %h", k, i, got, exp);
            end
         end
      end
      rst = 1'b1; start = 1'b0; ld = 1'b0; en = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) m[k] = '0;
      test_reset();
      test_periodic();
      test_wide_full();
      test_oneshot();
      test_loadnow();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
